// File: rtl/serial_sub_4bit.sv
// Bit-serial borrow-ripple subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Result after WIDTH busy cycles, done pulses the cycle after; start is ignored while busy.
module serial_sub_4bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             a_i;
  logic             b_i;
  logic             d;
  logic             br_nx;
  logic [WIDTH-1:0] res_nx;
  logic             last;

  // Single time-shared full-subtractor cell.
  assign a_i    = a_sh[0];
  assign b_i    = b_sh[0];
  assign d      = a_i ^ b_i ^ br;
  assign br_nx  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign res_nx = {d, res_sh[WIDTH-1:1]};
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            res_sh <= '0;
            cnt    <= '0;
            state  <= S_BUSY;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx;
          br     <= br_nx;
          cnt    <= cnt + 1'b1;
          // Outputs update only here so they are never seen half-built.
          if (last) begin
            diff  <= res_nx;
            bout  <= br_nx;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_4bit.sv
// Bench for serial_sub_4bit: arithmetic reference model checked every cycle plus directed literal checks.
module tb_serial_sub_4bit;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks = 0;
  int failures = 0;

  serial_sub_4bit #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a countdown of WIDTH busy cycles, result from plain arithmetic.
  int               left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bout = 1'b0;
  logic [WIDTH-1:0] p_diff = '0;
  logic             p_bout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = 0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0;
    end else if (left > 0) begin
      left = left - 1;
      if (left == 0) begin
        m_done = 1'b1; m_diff = p_diff; m_bout = p_bout;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        int diff_i;
        diff_i = int'(a) - int'(b) - int'(bin);
        p_diff = WIDTH'(diff_i);
        p_bout = (diff_i < 0);
        left = WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy", busy, (left > 0));
    chk("model_done", done, m_done);
    chk("model_diff", diff, m_diff);
    chk("model_bout", bout, m_bout);
  end

  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: quiet inputs; 1: scramble operands while busy; 2: pulse start mid-operation.
  task automatic wait_done(input int mode, output int nb);
    bit seen;
    seen = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) nb++;
      if (mode == 1) begin a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom); end
      if (mode == 2) begin
        start = (i == 1);
        a = 4'b1111; b = 4'b0000; bin = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_timeout", seen, 1'b1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int nb;
    int nd;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 4'b0000);
    chk("rst_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: basic op and latency
    launch(4'b0011, 4'b0001, 1'b0);
    wait_done(0, nb);
    chk("t1_busy_cycles", nb, 4);
    chk("t1_diff", diff, 4'b0010);
    chk("t1_bout", bout, 1'b0);
    @(negedge clk);

    // Test 2: operands change while busy
    launch(4'b1000, 4'b0110, 1'b0);
    wait_done(1, nb);
    chk("t2_diff", diff, 4'b0010);
    chk("t2_bout", bout, 1'b0);
    @(negedge clk);

    // Test 3: underflow cases
    launch(4'b0110, 4'b1010, 1'b1);
    wait_done(0, nb);
    chk("t3a_diff", diff, 4'b1011);
    chk("t3a_bout", bout, 1'b1);
    @(negedge clk);
    launch(4'b0000, 4'b0000, 1'b1);
    wait_done(0, nb);
    chk("t3b_diff", diff, 4'b1111);
    chk("t3b_bout", bout, 1'b1);

    // Test 4: back-to-back, start held during DONE
    launch(4'b0101, 4'b0011, 1'b1);
    chk("t4_no_idle", busy, 1'b1);
    chk("t4_hold_diff", diff, 4'b1111);
    wait_done(0, nb);
    chk("t4_busy_cycles", nb, 4);
    chk("t4_diff", diff, 4'b0001);
    chk("t4_bout", bout, 1'b0);
    @(negedge clk);

    // Test 5: start during BUSY ignored
    launch(4'b1001, 4'b0100, 1'b0);
    wait_done(2, nb);
    chk("t5_diff", diff, 4'b0101);
    count_dones(8, nd);
    chk("t5_single_done", nd, 0);

    // Test 6: asynchronous reset two cycles into BUSY
    launch(4'b1100, 4'b0001, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_diff", diff, 4'b0000);
    chk("t6_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(8, nd);
    chk("t6_no_done", nd, 0);
    launch(4'b1100, 4'b0001, 1'b0);
    wait_done(0, nb);
    chk("t6_diff_after", diff, 4'b1011);
    chk("t6_bout_after", bout, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      bin = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
